// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage F/D/E/M/W pipeline.
// Forwarding selects, load-use and multi-cycle stalls, branch flushes.
module hazard_ctrl #(
   parameter int ADDR_W     = 4,
   parameter int MC_LATENCY = 4,
   parameter int PC_REG     = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra1d,
   input  logic [ADDR_W-1:0] ra2d,
   input  logic [ADDR_W-1:0] ra1e,
   input  logic [ADDR_W-1:0] ra2e,
   input  logic [ADDR_W-1:0] wa3e,
   input  logic [ADDR_W-1:0] wa3m,
   input  logic [ADDR_W-1:0] wa3w,
   input  logic              regwritee,
   input  logic              regwritem,
   input  logic              regwritew,
   input  logic              memtorege,
   input  logic              branchtakene,
   input  logic              mcstarte,
   output logic [1:0]        forwardae,
   output logic [1:0]        forwardbe,
   output logic              stallf,
   output logic              stalld,
   output logic              stalle,
   output logic              flushd,
   output logic              flushe,
   output logic              flushm,
   output logic              mc_busy
);

   localparam int CNT_W = $clog2(MC_LATENCY);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] PC_A    = ADDR_W'(PC_REG);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mc_stall;
   logic             ldrstall;
   logic [1:0]       fwd_a, fwd_b;

   // M result is newer than W, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] ra);
      logic [1:0] sel;
      sel = 2'b00;
      if (ra != PC_A) begin
         if (regwritem && ra == wa3m)
            sel = 2'b10;
         else if (regwritew && ra == wa3w)
            sel = 2'b01;
      end
      return sel;
   endfunction

   // Operand forwarding selects for Execute.
   always_comb begin
      fwd_a = fwd_sel(ra1e);
      fwd_b = fwd_sel(ra2e);
   end

   // Load in E feeding either Decode source.
   always_comb begin
      ldrstall = memtorege & regwritee &
                 ((ra1d == wa3e) | (ra2d == wa3e));
   end

   // Multi-cycle sequencer: stall E for MC_LATENCY-1 cycles.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mc_stall = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mcstarte) begin
               mc_stall = 1'b1;
               state_d  = BUSY;
               cnt_d    = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               mc_stall = 1'b1;
               cnt_d    = cnt_q - CNT_ONE;
            end else begin
               state_d  = IDLE;
            end
         end
      endcase
   end

   // Sequencer state; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stall/flush priority; reset clears every stage register.
   always_comb begin
      forwardae = fwd_a;
      forwardbe = fwd_b;
      stallf    = 1'b0;
      stalld    = 1'b0;
      stalle    = 1'b0;
      flushd    = 1'b0;
      flushe    = 1'b0;
      flushm    = 1'b0;
      mc_busy   = 1'b0;
      if (reset) begin
         forwardae = 2'b00;
         forwardbe = 2'b00;
         flushd    = 1'b1;
         flushe    = 1'b1;
         flushm    = 1'b1;
      end else if (mc_stall) begin
         stallf  = 1'b1;
         stalld  = 1'b1;
         stalle  = 1'b1;
         flushm  = 1'b1;
         mc_busy = 1'b1;
      end else if (branchtakene) begin
         flushd = 1'b1;
         flushe = 1'b1;
      end else if (ldrstall) begin
         stallf = 1'b1;
         stalld = 1'b1;
         flushe = 1'b1;
      end
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and pipeline-control unit for the 5-stage pipeline (F, D, E, M, W).
- Drives the en/clear pair of every stage's enable-clear pipeline register:
  - stall outputs feed en as ~stall;
  - flush outputs feed clear.
- Also generates operand-forwarding selects for Execute.
- Sequences multi-cycle Execute operations (multiply/divide) with an internal busy counter.

Parameters:
- ADDR_W, 4, register-address width.
- MC_LATENCY, 4, total cycles a multi-cycle op occupies Execute; legal values are 2 to 16.
- PC_REG, 15, register index never forwarded (reads return PC-derived value).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- ra1d  input  ADDR_W  Decode source register 1.
- ra2d  input  ADDR_W  Decode source register 2.
- ra1e  input  ADDR_W  Execute source register 1.
- ra2e  input  ADDR_W  Execute source register 2.
- wa3e  input  ADDR_W  destination register, Execute.
- wa3m  input  ADDR_W  destination register, Memory.
- wa3w  input  ADDR_W  destination register, Writeback.
- regwritee  input  1  register write enable, Execute.
- regwritem  input  1  register write enable, Memory.
- regwritew  input  1  register write enable, Writeback.
- memtorege  input  1  Execute instruction is a load.
- branchtakene  input  1  branch resolved taken in Execute.
- mcstarte  input  1  Execute instruction is a multi-cycle op.
- forwardae  output  2  SrcA select: 00 register file, 01 W result, 10 M ALU result.
- forwardbe  output  2  SrcB select, same encoding.
- stallf  output  1  hold Fetch PC.
- stalld  output  1  hold F/D register.
- stalle  output  1  hold D/E register.
- flushd  output  1  clear F/D register.
- flushe  output  1  clear D/E register.
- flushm  output  1  clear E/M register.
- mc_busy  output  1  multi-cycle op in progress.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - Clears the FSM to IDLE and the counter to 0.
  - While reset=1, outputs are combinationally forced: all stalls 0; flushd=flushe=flushm=1; forwardae=forwardbe=00; mc_busy=0.
  - Reset mid-BUSY aborts the operation; no stall persists after reset deasserts.
- Forwarding (combinational), computed per operand X in {a,b}:
  - 10 if raXe==wa3m, regwritem=1 and raXe!=PC_REG.
  - else 01 if raXe==wa3w, regwritew=1 and raXe!=PC_REG.
  - else 00.
  - M has priority over W.
- ldrstall = memtorege & regwritee & (ra1d==wa3e | ra2d==wa3e).
- FSM states: IDLE and BUSY. Counter width is clog2(MC_LATENCY).
  - IDLE, mcstarte=1: assert mc stall this cycle; next state BUSY; counter loaded with MC_LATENCY-2.
  - BUSY, counter!=0: assert mc stall; decrement the counter.
  - BUSY, counter==0: no mc stall (completion cycle); next state IDLE.
  - BUSY ignores mcstarte, because the same instruction is still held in E.
  - Net effect: the instruction stays in E for exactly MC_LATENCY cycles; mc stall is high for MC_LATENCY-1 cycles.
- mc_busy = mc stall.
- Priority, highest first:
  1. mc stall: stallf=stalld=stalle=1, flushm=1 (bubble into M); flushd=flushe=0; branch and ldrstall ignored.
  2. branchtakene: flushd=flushe=1; all stalls 0. A branch overrides a simultaneous ldrstall, since the dependent instruction is squashed anyway.
  3. ldrstall: stallf=stalld=1, flushe=1; stalle=0, flushd=0, flushm=0.
  4. Otherwise all stall and flush outputs are 0.
- Invariant: a stage register's clear takes effect only when that register is enabled. Therefore flushd&stalld, flushe&stalle and flushm&stalle (E/M is enabled only when E advances… flushm itself targets an enabled E/M register) must never combine so that a requested clear is masked. Concretely, flushd&stalld==0 and flushe&stalle==0 in every cycle, including reset.
- No output registers. Stalls and flushes are combinational from the inputs and FSM state, so they act at the next clk edge.

Test Plan:
- Forward priority: ra1e=3, wa3m=3, regwritem=1, wa3w=3, regwritew=1 -> forwardae=10. Then regwritem=0 -> 01. Then ra1e=15 with both matching -> 00.
- Load-use: memtorege=1, regwritee=1, wa3e=5, ra2d=5 -> stallf=stalld=flushe=1, stalle=0 for exactly 1 cycle. Next cycle (memtorege=0) all 0.
- Multi-cycle: MC_LATENCY=4, mcstarte held high -> mc_busy/stalle/flushm high for cycles 0..2 and low at cycle 3. A new mcstarte at cycle 4 restarts the sequence. No restart occurs at cycle 3.
- Branch with load-use: branchtakene=1 and the ldrstall condition true in the same cycle -> flushd=flushe=1; stallf=stalld=stalle=0.
- Reset mid-operation: assert reset during cycle 1 of a BUSY sequence -> flushd=flushe=flushm=1 while reset is high. After reset deasserts with mcstarte=0: mc_busy=0 and all stalls 0.
- Invariant check: randomized inputs for 10k cycles -> flushd&stalld and flushe&stalle are never 1, and mc_busy never exceeds MC_LATENCY-1 consecutive cycles.
